asic_chain_responder: RTL and testbench



---
 rtl/asic_chain_responder_pkg.sv | 16 +
 rtl/asic_chain_responder_async_handshake_timer.sv | 92 +++++++++
 rtl/asic_chain_responder.sv | 92 +++++++++
 tb/tb_asic_chain_responder.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/asic_chain_responder_pkg.sv
// Shared constants for the ASIC chain responder: BIST decoder codes,
// the legacy 2-bit FSM state encodings and the default datapath sizes.
package asic_resp_pkg;

  localparam logic [2:0] BIST_NORMAL = 3'd6;
  localparam logic [2:0] BIST_FAULT  = 3'd5;

  localparam logic [1:0] SYNC       = 2'd0;
  localparam logic [1:0] ASYNC_IDLE = 2'd1;
  localparam logic [1:0] ASYNC_WAIT = 2'd2;
  localparam logic [1:0] ASYNC_ACK  = 2'd3;

  localparam int DEFAULT_WIDTH     = 6;
  localparam int DEFAULT_NUM_PATHS = 21;

endpackage

// File: rtl/asic_chain_responder_async_handshake_timer.sv
// Self-timed handshake sequencer for the chain responder: detects a change
// of K against the last captured word, counts ASYNC_LAT cycles (restarting
// if K moves again), fires capture_en, then stretches the acknowledge over
// ACK_CYCLES cycles. Owns the SYNC/ASYNC_* state register.
module async_handshake_timer
  import asic_resp_pkg::*;
#(
  parameter int WIDTH      = DEFAULT_WIDTH,
  parameter int ASYNC_LAT  = 3,
  parameter int ACK_CYCLES = 2
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] k,
  input  logic             async_mode,
  input  logic             suppress_ack,
  output logic             capture_en,
  output logic             ack,
  output logic             in_sync
);

  localparam int TW = (ASYNC_LAT > 1) ? $clog2(ASYNC_LAT) : 1;
  localparam int AW = (ACK_CYCLES > 1) ? $clog2(ACK_CYCLES) : 1;
  localparam logic [TW-1:0] LAT_LOAD = TW'(ASYNC_LAT - 1);
  localparam logic [AW-1:0] ACK_LOAD = AW'(ACK_CYCLES - 1);

  logic [1:0]       state;
  logic [TW-1:0]    timer;
  logic [AW-1:0]    ack_cnt;
  logic [WIDTH-1:0] k_seen;
  logic [WIDTH-1:0] k_pend;

  assign in_sync    = (state == SYNC);
  assign capture_en = async_mode && (state == ASYNC_WAIT) &&
                      (k == k_pend) && (timer == '0);

  // Handshake FSM: change detect, latency countdown, acknowledge stretch
  always_ff @(posedge clock) begin
    if (reset) begin
      state   <= SYNC;
      timer   <= '0;
      ack_cnt <= '0;
      k_seen  <= '0;
      k_pend  <= '0;
      ack     <= 1'b0;
    end else if (!async_mode) begin
      state   <= SYNC;
      timer   <= '0;
      ack_cnt <= '0;
      ack     <= 1'b0;
    end else begin
      case (state)
        SYNC: begin
          state <= ASYNC_IDLE;
          ack   <= 1'b0;
        end
        ASYNC_IDLE: begin
          ack <= 1'b0;
          if (k != k_seen) begin
            k_pend <= k;
            timer  <= LAT_LOAD;
            state  <= ASYNC_WAIT;
          end
        end
        ASYNC_WAIT: begin
          // a new K restarts the countdown against the newest word
          if (k != k_pend) begin
            k_pend <= k;
            timer  <= LAT_LOAD;
          end else if (timer == '0) begin
            k_seen  <= k;
            ack     <= ~suppress_ack;
            ack_cnt <= ACK_LOAD;
            state   <= ASYNC_ACK;
          end else begin
            timer <= timer - 1'b1;
          end
        end
        ASYNC_ACK: begin
          if (ack_cnt == '0) begin
            ack   <= 1'b0;
            state <= ASYNC_IDLE;
          end else begin
            ack_cnt <= ack_cnt - 1'b1;
          end
        end
        default: state <= SYNC;
      endcase
    end
  end

endmodule

// File: rtl/asic_chain_responder.sv
// ASIC chain test responder: direct / register / adder chain paths, a
// synchronous shadow-register diagnostic compare and an asynchronous
// self-timed handshake. Optional fault injection on bist code 5 is built
// only when ASIC_RESP_FAULT_INJECT_EN is defined.
module asic_chain_responder
  import asic_resp_pkg::*;
#(
  parameter int WIDTH      = DEFAULT_WIDTH,
  parameter int NUM_PATHS  = DEFAULT_NUM_PATHS,
  parameter int ASYNC_LAT  = 3,
  parameter int ACK_CYCLES = 2
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] K,
  input  logic             clock_mux_sel,
  input  logic             mode_mux_sel,
  input  logic [2:0]       bist_decoder_input,
  input  logic [4:0]       mux_decoder_input,
  input  logic             sel_chain_input,
  input  logic             sel_chain_output,
  output logic [WIDTH-1:0] chain_input,
  output logic [WIDTH-1:0] chain_output,
  output logic             comparison_result
);

  logic [WIDTH-1:0] chain_reg;
  logic [WIDTH-1:0] shadow_reg;
  logic [WIDTH-1:0] sum;
  logic [WIDTH-1:0] chain_next;
  logic [WIDTH-1:0] shadow_next;
  logic             cmp_reg;
  logic             fault;
  logic             capture_en;
  logic             ack;
  logic             in_sync;
  logic             sync_update;
  logic             path_ok;

  assign sum          = K + chain_reg;
  assign chain_input  = (mode_mux_sel | ~sel_chain_input) ? K : sum;
  assign chain_output = sel_chain_output ? chain_reg : chain_input;

`ifdef ASIC_RESP_FAULT_INJECT_EN
  assign fault = (bist_decoder_input == BIST_FAULT);
`else
  logic unused_bist;
  assign unused_bist = ^bist_decoder_input;
  assign fault       = 1'b0;
`endif

  // shadow mirrors the chain update through a separately built mux so the
  // compare catches a corrupted chain write
  assign chain_next  = chain_input ^ {{(WIDTH-1){1'b0}}, fault};
  assign shadow_next = mode_mux_sel ? K : (sel_chain_input ? K + chain_reg : K);

  assign path_ok     = int'(mux_decoder_input) < NUM_PATHS;
  assign sync_update = in_sync & ~clock_mux_sel;

  async_handshake_timer #(
    .WIDTH      (WIDTH),
    .ASYNC_LAT  (ASYNC_LAT),
    .ACK_CYCLES (ACK_CYCLES)
  ) u_timer (
    .clock        (clock),
    .reset        (reset),
    .k            (K),
    .async_mode   (clock_mux_sel),
    .suppress_ack (fault),
    .capture_en   (capture_en),
    .ack          (ack),
    .in_sync      (in_sync)
  );

  // Chain and shadow registers plus the registered sync-mode compare
  always_ff @(posedge clock) begin
    if (reset) begin
      chain_reg  <= '0;
      shadow_reg <= '0;
      cmp_reg    <= 1'b0;
    end else begin
      if (sync_update || capture_en) begin
        chain_reg  <= chain_next;
        shadow_reg <= shadow_next;
      end
      cmp_reg <= sync_update && (chain_reg == shadow_reg) && path_ok;
    end
  end

  assign comparison_result = in_sync ? cmp_reg : ack;

endmodule

// File: tb/tb_asic_chain_responder.sv
// Self-checking bench for asic_chain_responder: path sweeps, a vector table
// for adder / async handshake / reset / fault sequences, and randomized
// sync-mode stimulus against a behavioural model.
module tb_asic_chain_responder;

`ifdef ASIC_RESP_FAULT_INJECT_EN
  localparam bit FI = 1'b1;
`else
  localparam bit FI = 1'b0;
`endif

  logic       clock = 1'b0;
  logic       reset;
  logic [5:0] K;
  logic       clock_mux_sel, mode_mux_sel, sel_chain_input, sel_chain_output;
  logic [2:0] bist_decoder_input;
  logic [4:0] mux_decoder_input;
  logic [5:0] chain_input, chain_output;
  logic       comparison_result;

  int vectors = 0;
  int miscompares = 0;

  always #5 clock = ~clock;

  asic_chain_responder #(
    .WIDTH(6), .NUM_PATHS(21), .ASYNC_LAT(3), .ACK_CYCLES(2)
  ) dut (
    .clock(clock), .reset(reset), .K(K),
    .clock_mux_sel(clock_mux_sel), .mode_mux_sel(mode_mux_sel),
    .bist_decoder_input(bist_decoder_input),
    .mux_decoder_input(mux_decoder_input),
    .sel_chain_input(sel_chain_input), .sel_chain_output(sel_chain_output),
    .chain_input(chain_input), .chain_output(chain_output),
    .comparison_result(comparison_result)
  );

  typedef struct {
    logic       rst;
    logic       cms;
    logic       mms;
    logic       sci;
    logic [5:0] k;
    logic [4:0] mux;
    logic [2:0] bist;
    logic [5:0] exp_co;
    logic       exp_cr;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic add(input logic rst, input logic cms, input logic mms,
                     input logic sci, input int k, input int mux,
                     input int bist, input int co, input logic cr);
    vec_t v;
    v.rst = rst; v.cms = cms; v.mms = mms; v.sci = sci;
    v.k = 6'(k); v.mux = 5'(mux); v.bist = 3'(bist);
    v.exp_co = 6'(co); v.exp_cr = cr;
    vecs.push_back(v);
  endtask

  initial begin
    logic [5:0] m_chain;
    logic [5:0] exp_ci;
    logic       exp_cr;

    reset = 1'b1; K = '0; clock_mux_sel = 1'b0; mode_mux_sel = 1'b1;
    sel_chain_input = 1'b0; sel_chain_output = 1'b0;
    bist_decoder_input = 3'd6; mux_decoder_input = '0;
    step(); step();
    check("reset_co", int'(chain_output), 0);
    check("reset_cr", int'(comparison_result), 0);
    reset = 1'b0;

    // direct path: combinational K -> chain_output
    for (int k = 0; k < 64; k++) begin
      K = 6'(k); #1;
      check($sformatf("direct_k%0d", k), int'(chain_output), k);
      step();
    end

    // register path: one cycle latency
    sel_chain_output = 1'b1;
    for (int k = 0; k < 64; k++) begin
      K = 6'(k);
      step();
      check($sformatf("regpath_k%0d", k), int'(chain_output), k);
    end

    // rst cms mms sci k mux bist co cr
    add(1, 0, 1, 0,  9,  0, 6,  0, 0);
    add(1, 0, 1, 0, 33,  0, 6,  0, 0);
    add(0, 0, 0, 1,  5,  0, 6,  5, 1);   // adder 5, 10, 15
    add(0, 0, 0, 1,  5,  0, 6, 10, 1);
    add(0, 0, 0, 1,  5,  0, 6, 15, 1);
    add(0, 0, 0, 1, 63,  0, 6, 14, 1);   // 63 + 15 wraps to 14
    add(0, 0, 0, 1, 63, 21, 6, 13, 0);   // out-of-range path
    add(0, 0, 1, 0,  0,  0, 6,  0, 1);
    add(0, 1, 1, 0,  0,  0, 6,  0, 0);   // enter async, chain holds
    add(0, 1, 1, 0,  0,  0, 6,  0, 0);
    add(0, 1, 1, 0,  1,  0, 6,  0, 0);   // K change detected
    add(0, 1, 1, 0,  1,  0, 6,  0, 0);
    add(0, 1, 1, 0,  1,  0, 6,  0, 0);
    add(0, 1, 1, 0,  1,  0, 6,  1, 1);   // capture + ack
    add(0, 1, 1, 0,  2,  0, 6,  1, 1);   // K change during ack ignored
    add(0, 1, 1, 0,  2,  0, 6,  1, 0);   // back to idle
    add(0, 1, 1, 0,  2,  0, 6,  1, 0);   // detected in idle
    add(0, 1, 1, 0,  2,  0, 6,  1, 0);
    add(0, 1, 1, 0,  2,  0, 6,  1, 0);
    add(0, 1, 1, 0,  2,  0, 6,  2, 1);
    add(0, 1, 1, 0,  2,  0, 6,  2, 1);
    add(0, 1, 1, 0,  2,  0, 6,  2, 0);
    add(0, 1, 1, 0,  3,  0, 6,  2, 0);   // detect 3
    add(0, 1, 1, 0,  3,  0, 6,  2, 0);
    add(0, 1, 1, 0,  4,  0, 6,  2, 0);   // change in wait restarts
    add(0, 1, 1, 0,  4,  0, 6,  2, 0);
    add(0, 1, 1, 0,  4,  0, 6,  2, 0);
    add(0, 1, 1, 0,  4,  0, 6,  4, 1);
    add(0, 1, 1, 0,  4,  0, 6,  4, 1);
    add(0, 1, 1, 0,  4,  0, 6,  4, 0);
    add(0, 1, 1, 0,  9,  0, 6,  4, 0);   // detect 9
    add(1, 1, 1, 0,  9,  0, 6,  0, 0);   // reset aborts handshake
    add(0, 1, 1, 0,  0,  0, 6,  0, 0);
    add(0, 1, 1, 0,  1,  0, 6,  0, 0);   // K=1 after reset triggers
    add(0, 1, 1, 0,  1,  0, 6,  0, 0);
    add(0, 1, 1, 0,  1,  0, 6,  0, 0);
    add(0, 1, 1, 0,  1,  0, 6,  1, 1);
    add(0, 1, 1, 0,  1,  0, 6,  1, 1);
    add(0, 0, 1, 0,  7,  0, 6,  1, 0);   // drop to sync mid-ack
    add(0, 0, 1, 0,  7,  0, 6,  7, 1);
    add(0, 0, 1, 0,  7,  0, 5, FI ? 6 : 7, 1);
    add(0, 0, 1, 0,  7,  0, 5, FI ? 6 : 7, FI ? 1'b0 : 1'b1);
    add(0, 0, 1, 0,  7,  0, 6,  7, FI ? 1'b0 : 1'b1);
    add(0, 0, 1, 0,  7,  0, 6,  7, 1);

    sel_chain_output = 1'b1;
    foreach (vecs[i]) begin
      reset = vecs[i].rst; clock_mux_sel = vecs[i].cms;
      mode_mux_sel = vecs[i].mms; sel_chain_input = vecs[i].sci;
      K = vecs[i].k; mux_decoder_input = vecs[i].mux;
      bist_decoder_input = vecs[i].bist;
      step();
      check($sformatf("vec%0d_co", i), int'(chain_output), int'(vecs[i].exp_co));
      check($sformatf("vec%0d_cr", i), int'(comparison_result), int'(vecs[i].exp_cr));
    end

    // randomized sync mode against a behavioural model
    m_chain = 6'd7;
    clock_mux_sel = 1'b0;
    for (int i = 0; i < 300; i++) begin
      reset = ($urandom_range(0, 15) == 0);
      K = 6'($urandom_range(0, 63));
      mode_mux_sel = 1'($urandom_range(0, 1));
      sel_chain_input = 1'($urandom_range(0, 1));
      sel_chain_output = 1'($urandom_range(0, 1));
      mux_decoder_input = 5'($urandom_range(0, 31));
      bist_decoder_input = 3'($urandom_range(0, 7));
      if (FI && bist_decoder_input == 3'd5) bist_decoder_input = 3'd6;
      #1;
      exp_ci = (mode_mux_sel || !sel_chain_input) ? K : 6'((int'(K) + int'(m_chain)) % 64);
      check($sformatf("rnd%0d_ci", i), int'(chain_input), int'(exp_ci));
      step();
      if (reset) begin
        m_chain = '0;
        exp_cr  = 1'b0;
      end else begin
        m_chain = exp_ci;
        exp_cr  = (int'(mux_decoder_input) < 21);
      end
      exp_ci = (mode_mux_sel || !sel_chain_input) ? K : 6'((int'(K) + int'(m_chain)) % 64);
      check($sformatf("rnd%0d_co", i), int'(chain_output),
            sel_chain_output ? int'(m_chain) : int'(exp_ci));
      check($sformatf("rnd%0d_cr", i), int'(comparison_result), int'(exp_cr));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
